// File: rtl/sine_lut_arbiter_if.sv
// rtl/sine_lut_arbiter_if.sv - client request/grant, ROM and response bundle for sine_lut_arbiter
interface sine_lut_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0]        i_req;
  logic [NUM_REQ*ADDR_W-1:0] i_addr;
  logic [NUM_REQ-1:0]        o_gnt;
  logic                      o_rom_en;
  logic [ADDR_W-1:0]         o_rom_addr;
  logic [DATA_W-1:0]         i_rom_data;
  logic [NUM_REQ-1:0]        o_rsp_valid;
  logic [DATA_W-1:0]         o_rsp_data;

  modport slave (
    input  i_req, i_addr, i_rom_data,
    output o_gnt, o_rom_en, o_rom_addr, o_rsp_valid, o_rsp_data
  );

  modport master (
    output i_req, i_addr, i_rom_data,
    input  o_gnt, o_rom_en, o_rom_addr, o_rsp_valid, o_rsp_data
  );
endinterface

// File: rtl/sine_lut_arbiter.sv
// rtl/sine_lut_arbiter.sv - shares one sine ROM between NUM_REQ clients, returns tagged samples in order
// Define SINE_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module sine_lut_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  sine_lut_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]             gnt;
  logic [PTR_W-1:0]               gnt_idx;
  logic                           gnt_any;
  logic [ADDR_W-1:0]              addr_sel;
  logic                           rom_en;
  logic [ADDR_W-1:0]              rom_addr;
  // Stage 0 rides alongside rom_en; stages 1..ROM_LAT track the ROM latency.
  logic [ROM_LAT:0][NUM_REQ-1:0]  tag_q;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]              rsp_data;

`ifdef SINE_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.i_req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = PTR_W'(i);
      end
    end
  end
`else
  logic [PTR_W-1:0] last_gnt;
  logic [PTR_W-1:0] cand;

  // Scan from farthest to nearest so the client right after last_gnt wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PTR_W'((int'(last_gnt) + i) % NUM_REQ);
      if (bus.i_req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_gnt <= PTR_W'(NUM_REQ - 1);
    end else if (gnt_any) begin
      last_gnt <= gnt_idx;
    end
  end
`endif

  always_comb begin
    gnt      = '0;
    addr_sel = '0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        addr_sel = bus.i_addr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      tag_q     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rom_en <= gnt_any;
      if (gnt_any) begin
        rom_addr <= addr_sel;
      end
      tag_q     <= {tag_q[ROM_LAT-1:0], gnt};
      rsp_valid <= tag_q[ROM_LAT];
      if (|tag_q[ROM_LAT]) begin
        rsp_data <= bus.i_rom_data;
      end
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_rom_en    = rom_en;
  assign bus.o_rom_addr  = rom_addr;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = rsp_data;
endmodule
